// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - instruction-register / datapath control bundle for multicycle_control
interface multicycle_control_if #(
   parameter int CNT_W = 32
) ();
   logic [5:0]       op;
   logic [5:0]       funct;
   logic             zero;
   logic             PCWr;
   logic             IRWr;
   logic [1:0]       WRsel;
   logic [1:0]       WDsel;
   logic             RFWr;
   logic             EXTOp;
   logic             Bsel;
   logic [1:0]       ALUOp;
   logic             DMWr;
   logic             Br;
   logic             LUIsel;
   logic             Jal;
   logic             Jr;
   logic [2:0]       state;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      input  op, funct, zero,
      output PCWr, IRWr, WRsel, WDsel, RFWr, EXTOp, Bsel, ALUOp, DMWr,
             Br, LUIsel, Jal, Jr, state, illegal, retired
   );

   modport slave (
      output op, funct, zero,
      input  PCWr, IRWr, WRsel, WDsel, RFWr, EXTOp, Bsel, ALUOp, DMWr,
             Br, LUIsel, Jal, Jr, state, illegal, retired
   );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM (FETCH/DECODE/EXE/MEM/WB) with retire counter
module multicycle_control #(
   parameter int MEM_WAIT = 0,
   parameter int CNT_W    = 32
) (
   input logic                   clk,
   input logic                   reset,
   multicycle_control_if.master  bus
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXE    = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

   state_t           cur;
   state_t           nxt;
   logic [3:0]       wcnt;
   logic [CNT_W-1:0] count;

   logic is_addu, is_subu, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_jal;
   logic legal, mem_last, retire;
   logic pc_wr, ir_wr, rf_wr, ext_op, b_sel, dm_wr, br, lui_sel, jal, jr, ill;
   logic [1:0] wr_sel, wd_sel, alu_op;

   assign is_addu  = (bus.op == 6'b000000) && (bus.funct == 6'b100001);
   assign is_subu  = (bus.op == 6'b000000) && (bus.funct == 6'b100011);
   assign is_jr    = (bus.op == 6'b000000) && (bus.funct == 6'b001000);
   assign is_ori   = (bus.op == 6'b001101);
   assign is_lw    = (bus.op == 6'b100011);
   assign is_sw    = (bus.op == 6'b101011);
   assign is_beq   = (bus.op == 6'b000100);
   assign is_lui   = (bus.op == 6'b001111);
   assign is_jal   = (bus.op == 6'b000011);
   assign legal    = is_addu | is_subu | is_jr | is_ori | is_lw | is_sw | is_beq | is_lui | is_jal;
   assign mem_last = (wcnt == WAIT_LAST);

   always_comb begin
      nxt = cur;
      pc_wr = 1'b0; ir_wr = 1'b0; rf_wr = 1'b0; ext_op = 1'b0; b_sel = 1'b0;
      dm_wr = 1'b0; br = 1'b0; lui_sel = 1'b0; jal = 1'b0; jr = 1'b0; ill = 1'b0;
      wr_sel = 2'b00; wd_sel = 2'b00; alu_op = 2'b00;
      case (cur)
         FETCH: begin
            ir_wr = 1'b1;
            pc_wr = 1'b1;
            nxt   = DECODE;
         end
         DECODE: begin
            if (is_jal) begin
               jal = 1'b1; pc_wr = 1'b1; rf_wr = 1'b1;
               wr_sel = 2'b10; wd_sel = 2'b10;
               nxt = FETCH;
            end else if (is_jr) begin
               jr = 1'b1; pc_wr = 1'b1;
               nxt = FETCH;
            end else if (!legal) begin
               ill = 1'b1;
               nxt = FETCH;
            end else begin
               nxt = EXE;
            end
         end
         EXE: begin
            nxt = FETCH;
            if (is_addu || is_subu) begin
               alu_op = is_subu ? 2'b01 : 2'b00;
               nxt = WB;
            end else if (is_ori) begin
               alu_op = 2'b10; b_sel = 1'b1;
               nxt = WB;
            end else if (is_lui) begin
               lui_sel = 1'b1; b_sel = 1'b1;
               nxt = WB;
            end else if (is_lw || is_sw) begin
               b_sel = 1'b1; ext_op = 1'b1;
               nxt = MEM;
            end else if (is_beq) begin
               alu_op = 2'b01; ext_op = 1'b1; br = 1'b1; pc_wr = bus.zero;
            end
         end
         MEM: begin
            // Address selects stay held so the DM address is stable across the wait.
            if (is_lw || is_sw) begin
               b_sel = 1'b1; ext_op = 1'b1;
            end
            dm_wr = is_sw && mem_last;
            if (mem_last) nxt = is_lw ? WB : FETCH;
         end
         WB: begin
            rf_wr = 1'b1;
            if (is_addu || is_subu) wr_sel = 2'b01;
            if (is_ori) begin
               alu_op = 2'b10; b_sel = 1'b1;
            end
            if (is_lui) begin
               lui_sel = 1'b1; b_sel = 1'b1;
            end
            if (is_lw) wd_sel = 2'b01;
            nxt = FETCH;
         end
         default: nxt = FETCH;
      endcase
      retire = (cur != FETCH) && (nxt == FETCH) && !(cur == DECODE && !legal);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur   <= FETCH;
         wcnt  <= 4'd0;
         count <= '0;
      end else begin
         cur <= nxt;
         if (cur != MEM)
            wcnt <= 4'd0;
         else if (!mem_last)
            wcnt <= wcnt + 4'd1;
         if (retire) count <= count + 1'b1;
      end
   end

   assign bus.PCWr    = pc_wr   & ~reset;
   assign bus.IRWr    = ir_wr   & ~reset;
   assign bus.RFWr    = rf_wr   & ~reset;
   assign bus.EXTOp   = ext_op  & ~reset;
   assign bus.Bsel    = b_sel   & ~reset;
   assign bus.DMWr    = dm_wr   & ~reset;
   assign bus.Br      = br      & ~reset;
   assign bus.LUIsel  = lui_sel & ~reset;
   assign bus.Jal     = jal     & ~reset;
   assign bus.Jr      = jr      & ~reset;
   assign bus.illegal = ill     & ~reset;
   assign bus.WRsel   = reset ? 2'b00 : wr_sel;
   assign bus.WDsel   = reset ? 2'b00 : wd_sel;
   assign bus.ALUOp   = reset ? 2'b00 : alu_op;
   assign bus.state   = cur;
   assign bus.retired = reset ? '0 : count;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control (MEM_WAIT=2, CNT_W=4)
module tb_multicycle_control;
   localparam int MW = 2;
   localparam int CW = 4;

   localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LW = 4;
   localparam int K_SW = 5, K_BEQ = 6, K_LUI = 7, K_JAL = 8, K_ILL = 9;

   typedef struct packed {
      logic [2:0] state;
      logic       PCWr, IRWr;
      logic [1:0] WRsel, WDsel;
      logic       RFWr, EXTOp, Bsel;
      logic [1:0] ALUOp;
      logic       DMWr, Br, LUIsel, Jal, Jr, illegal;
      logic [CW-1:0] retired;
   } obs_t;

   logic clk = 1'b0;
   logic reset;
   multicycle_control_if #(.CNT_W(CW)) bus ();

   multicycle_control #(.MEM_WAIT(MW), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   obs_t    sb[$];
   string   names[$];
   int      checks = 0;
   int      passed = 0;
   int      pushed;
   int      abort_at;
   logic [CW-1:0] cnt = '0;
   bit      first_ill = 1'b1;

   always @(negedge clk) begin
      obs_t act, exp_o;
      string nm;
      if (sb.size() > 0) begin
         exp_o = sb.pop_front();
         nm    = names.pop_front();
         act.state = bus.state;   act.PCWr = bus.PCWr;     act.IRWr = bus.IRWr;
         act.WRsel = bus.WRsel;   act.WDsel = bus.WDsel;   act.RFWr = bus.RFWr;
         act.EXTOp = bus.EXTOp;   act.Bsel = bus.Bsel;     act.ALUOp = bus.ALUOp;
         act.DMWr = bus.DMWr;     act.Br = bus.Br;         act.LUIsel = bus.LUIsel;
         act.Jal = bus.Jal;       act.Jr = bus.Jr;         act.illegal = bus.illegal;
         act.retired = bus.retired;
         checks++;
         if (act !== exp_o)
            $display("FAIL %s @%0t: got %h (state %0d retired %0d) expected %h (state %0d retired %0d)",
                     nm, $time, act, act.state, act.retired, exp_o, exp_o.state, exp_o.retired);
         else
            passed++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Queue one cycle's expectation; the cycle at abort_at becomes a reset cycle.
   task automatic pushr(input obs_t o, input string nm);
      obs_t r;
      if (abort_at >= 0 && pushed > abort_at) return;
      if (pushed == abort_at) begin
         r = '0;
         r.state = o.state;
         o = r;
         nm = {nm, "_in_reset"};
      end
      sb.push_back(o);
      names.push_back(nm);
      pushed++;
   endtask

   task automatic set_instr(input int k);
      logic [5:0] o6, f6;
      f6 = 6'($urandom);
      case (k)
         K_ADDU: begin o6 = 6'b000000; f6 = 6'b100001; end
         K_SUBU: begin o6 = 6'b000000; f6 = 6'b100011; end
         K_JR:   begin o6 = 6'b000000; f6 = 6'b001000; end
         K_ORI:  o6 = 6'b001101;
         K_LW:   o6 = 6'b100011;
         K_SW:   o6 = 6'b101011;
         K_BEQ:  o6 = 6'b000100;
         K_LUI:  o6 = 6'b001111;
         K_JAL:  o6 = 6'b000011;
         default: begin
            if (first_ill) begin
               o6 = 6'b111111;
               first_ill = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
               o6 = 6'b000000;
               do f6 = 6'($urandom); while (f6 == 6'b100001 || f6 == 6'b100011 || f6 == 6'b001000);
            end else begin
               do o6 = 6'($urandom);
               while (o6 inside {6'b000000, 6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b001111, 6'b000011});
            end
         end
      endcase
      bus.op    = o6;
      bus.funct = f6;
   endtask

   // Issue one instruction and push its whole expected cycle trace.
   task automatic issue(input int k, input int zsel, input int abort);
      obs_t o, e, w;
      logic z;
      set_instr(k);
      z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      bus.zero = z;
      pushed   = 0;
      abort_at = abort;

      o = '0; o.retired = cnt; o.IRWr = 1'b1; o.PCWr = 1'b1;
      pushr(o, "fetch");
      o = '0; o.retired = cnt; o.state = 3'd1;
      if (k == K_JAL) begin
         o.Jal = 1'b1; o.PCWr = 1'b1; o.RFWr = 1'b1; o.WRsel = 2'b10; o.WDsel = 2'b10;
         pushr(o, "jal_decode");
      end else if (k == K_JR) begin
         o.Jr = 1'b1; o.PCWr = 1'b1;
         pushr(o, "jr_decode");
      end else if (k == K_ILL) begin
         o.illegal = 1'b1;
         pushr(o, "illegal_decode");
      end else begin
         pushr(o, "decode");
         e = '0; e.retired = cnt; e.state = 3'd2;
         case (k)
            K_SUBU: e.ALUOp = 2'b01;
            K_ORI:  begin e.ALUOp = 2'b10; e.Bsel = 1'b1; end
            K_LUI:  begin e.LUIsel = 1'b1; e.Bsel = 1'b1; end
            K_LW, K_SW: begin e.Bsel = 1'b1; e.EXTOp = 1'b1; end
            K_BEQ:  begin e.ALUOp = 2'b01; e.EXTOp = 1'b1; e.Br = 1'b1; e.PCWr = z; end
            default: ;
         endcase
         pushr(e, "exe");
         if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= MW; i++) begin
               o = e;
               o.state = 3'd3;
               o.DMWr = (k == K_SW) && (i == MW);
               pushr(o, "mem");
            end
         end
         if (k != K_SW && k != K_BEQ) begin
            w = (k == K_ORI || k == K_LUI) ? e : obs_t'(0);
            w.retired = cnt; w.state = 3'd4; w.RFWr = 1'b1;
            w.WRsel = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
            w.WDsel = (k == K_LW) ? 2'b01 : 2'b00;
            pushr(w, "wb");
         end
      end

      if (abort >= 0) begin
         repeat (abort) step();
         reset = 1'b1;
         step();
         reset = 1'b0;
         cnt = '0;
      end else begin
         repeat (pushed) step();
         if (k != K_ILL) cnt = cnt + 1'b1;
      end
   endtask

   initial begin
      obs_t r;
      reset = 1'b1;
      bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
      abort_at = -1;
      r = '0;
      repeat (2) begin
         step();
         sb.push_back(r);
         names.push_back("reset");
      end
      step();
      reset = 1'b0;

      issue(K_ADDU, -1, -1);
      issue(K_SW,   -1, -1);
      issue(K_LW,   -1, -1);
      issue(K_BEQ,   1, -1);
      issue(K_BEQ,   0, -1);
      issue(K_JAL,  -1, -1);
      issue(K_JR,   -1, -1);
      issue(K_ILL,  -1, -1);
      issue(K_ADDU, -1, -1);
      issue(K_SUBU, -1, -1);
      issue(K_ORI,  -1, -1);
      issue(K_LUI,  -1, -1);
      for (int n = 0; n < 70; n++)
         issue(int'($urandom_range(0, 9)), -1, -1);
      issue(K_LW, -1, 4);
      issue(K_ADDU, -1, -1);
      issue(K_SW, -1, 3 + MW);
      issue(K_ORI, -1, -1);

      step();
      step();
      checks++;
      if (sb.size() != 0)
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      else
         passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
